// File: rtl/ub_activation_feeder.sv
// Unified-buffer activation feeder: fetches 2xN activations, saturates them
// to 16 bits and streams them skewed into a two-row systolic array.
module ub_activation_feeder #(
  parameter int ADDR_W   = 6,
  parameter int MAX_ROWS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [3:0]               num_rows,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [31:0]       rd_data,
  output logic                     valid,
  output logic [15:0]              a_in1,
  output logic [15:0]              a_in2,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(2*MAX_ROWS+1);
  localparam int IW = $clog2(2*MAX_ROWS);
  localparam logic [CW-1:0] MAXN = CW'(MAX_ROWS);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     n_q, n2, n_eff, cnt;
  logic              cap_vld;
  logic [IW-1:0]     cap_idx, idx1, idx2;
  logic [15:0]       sat_val;
  logic [15:0]       act_buf [2*MAX_ROWS];

  assign n_eff = (CW'(num_rows) > MAXN) ? MAXN : CW'(num_rows);
  assign n2    = n_q << 1;
  assign idx1  = IW'(cnt << 1);
  assign idx2  = IW'((cnt << 1) - CW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = (n_eff == '0) ? DONE : FETCH;
      FETCH:  if (cnt == n2) state_nx = STREAM;
      STREAM: if (cnt == n_q) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FETCH holds one extra cycle (cnt == 2N) to capture the last word
  always_comb begin
    rd_en   = (state == FETCH) && (cnt != n2);
    rd_addr = rd_en ? base_q + ADDR_W'(cnt) : '0;
    valid   = (state == STREAM);
    a_in1   = (valid && cnt != n_q) ? act_buf[idx1] : '0;
    a_in2   = (valid && cnt != '0) ? act_buf[idx2] : '0;
    busy    = (state != IDLE);
    done    = (state == DONE);
  end

  always_comb begin
    sat_val = rd_data[15:0];
    if (rd_data > 32'sd32767)
      sat_val = 16'h7FFF;
    else if (rd_data < -32'sd32768)
      sat_val = 16'h8000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      base_q  <= '0;
      n_q     <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
    end else begin
      state   <= state_nx;
      cap_vld <= rd_en;
      cap_idx <= IW'(cnt);
      if (state == IDLE && start) begin
        base_q <= base_addr;
        n_q    <= n_eff;
      end
      if (state_nx != state || state == IDLE || state == DONE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_vld) act_buf[cap_idx] <= sat_val;
  end

endmodule

// File: tb/tb_ub_activation_feeder.sv
// Directed bench for ub_activation_feeder with a one-cycle-latency
// unified-buffer model.
module tb_ub_activation_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_addr;
  logic [3:0]  num_rows;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        valid;
  logic [15:0] a_in1;
  logic [15:0] a_in2;
  logic        busy;
  logic        done;

  logic [31:0] mem [64];
  logic [15:0] ex0 [9];
  logic [15:0] ex1 [9];
  int n_checks = 0;
  int n_fail   = 0;

  ub_activation_feeder #(.ADDR_W(6), .MAX_ROWS(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_rows(num_rows),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .valid(valid), .a_in1(a_in1), .a_in2(a_in2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rd_data <= rd_en ? mem[rd_addr] : 32'hDEADBEEF;

  function automatic logic [41:0] pk(
    logic re, logic [5:0] ad, logic v,
    logic [15:0] a1, logic [15:0] a2, logic b, logic d);
    return {re, ad, v, a1, a2, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [41:0] exp);
    logic [41:0] obs;
    obs = {rd_en, rd_addr, valid, a_in1, a_in2, busy, done};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // full transfer; poke = stream cycle in which start is pulsed (-1 none)
  task automatic xfer(string tag, logic [5:0] base,
                      logic [3:0] nr, int n, int poke);
    logic [5:0] a;
    logic [15:0] e1, e2;
    base_addr = base;
    num_rows  = nr;
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk({tag, " done"}, pk(0, 0, 0, 0, 0, 1, 1));
      tick();
      chk({tag, " idle"}, '0);
      return;
    end
    for (int k = 0; k < 2*n; k++) begin
      a = base + 6'(k);
      chk($sformatf("%s rd%0d", tag, k), pk(1, a, 0, 0, 0, 1, 0));
      tick();
    end
    chk({tag, " wait"}, pk(0, 0, 0, 0, 0, 1, 0));
    tick();
    for (int s = 0; s <= n; s++) begin
      e1 = (s < n) ? ex0[s] : 16'h0;
      e2 = (s > 0) ? ex1[s-1] : 16'h0;
      chk($sformatf("%s st%0d", tag, s), pk(0, 0, 1, e1, e2, 1, 0));
      start = (s == poke);
      tick();
    end
    start = 1'b0;
    chk({tag, " done"}, pk(0, 0, 0, 0, 0, 1, 1));
    tick();
    chk({tag, " idle"}, '0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000AAAA;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
    tick(); tick();
    chk("reset", '0);
    start = 1'b1;
    tick();
    chk("reset_vs_start", '0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("idle_after_rst", '0);

    mem[4] = 1; mem[5] = 2; mem[6] = 3; mem[7] = 4;
    ex0[0] = 1; ex1[0] = 2; ex0[1] = 3; ex1[1] = 4;
    xfer("basic", 6'd4, 4'd2, 2, -1);

    mem[62] = 5; mem[63] = 6;
    ex0[0] = 5; ex1[0] = 6;
    xfer("wrap", 6'd62, 4'd1, 1, -1);

    mem[10] = 32'h00010000; mem[11] = 32'hFFFE0000;
    mem[12] = 32'hFFFFFFF6; mem[13] = 32'h00007FFF;
    mem[14] = 32'hFFFF8000; mem[15] = 32'h00008000;
    ex0[0] = 16'h7FFF; ex1[0] = 16'h8000;
    ex0[1] = 16'hFFF6; ex1[1] = 16'h7FFF;
    ex0[2] = 16'h8000; ex1[2] = 16'h7FFF;
    xfer("sat", 6'd10, 4'd3, 3, -1);

    xfer("zero", 6'd4, 4'd0, 0, -1);

    for (int k = 0; k < 24; k++) mem[20+k] = 32'(100 + k);
    for (int r = 0; r < 8; r++) begin
      ex0[r] = 16'(100 + 2*r);
      ex1[r] = 16'(101 + 2*r);
    end
    xfer("clamp", 6'd20, 4'd12, 8, -1);

    ex0[0] = 1; ex1[0] = 2; ex0[1] = 3; ex1[1] = 4;
    xfer("poke", 6'd4, 4'd2, 2, 1);
    tick();
    chk("poke_no_2nd", '0);

    base_addr = 6'd4; num_rows = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("abort st0", pk(0, 0, 1, 16'd1, 16'd0, 1, 0));
    tick();
    chk("abort st1", pk(0, 0, 1, 16'd3, 16'd2, 1, 0));
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("abort out0", '0);
    tick();
    chk("abort nodone", '0);

    xfer("restart", 6'd4, 4'd2, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ub_activation_feeder.md
UB_ACTIVATION_FEEDER -- requirements
Module: ub_activation_feeder

Interface
REQ-001 Parameter ADDR_W, default 6: unified-buffer word-address width (64 words).
REQ-002 Parameter MAX_ROWS, default 8: maximum activation rows per transfer.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  unified-buffer word address of element X[0][0].
REQ-007 num_rows  input  4  activation rows N; sampled with start.
REQ-008 rd_en  output  1  unified-buffer read strobe.
REQ-009 rd_addr  output  ADDR_W  unified-buffer read address.
REQ-010 rd_data  input  32  signed read data, valid exactly one cycle after the rd_en cycle.
REQ-011 valid  output  1  activation stream valid toward the systolic array.
REQ-012 a_in1  output  16  activation for PE row 0.
REQ-013 a_in2  output  16  activation for PE row 1, skewed one cycle behind a_in1.
REQ-014 busy  output  1  high from the cycle after an accepted start until the cycle after done.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, STREAM and DONE.
REQ-017 In IDLE, start=1 SHALL latch base_addr and the effective N (num_rows clamped to MAX_ROWS) and transition to FETCH, or to DONE if N=0.
REQ-018 In FETCH, the block SHALL assert rd_en for exactly 2N consecutive cycles with rd_addr = base_addr+k (k=0..2N-1), wrapping modulo 2^ADDR_W.
REQ-019 Word base+2r SHALL hold X[r][0] and word base+2r+1 SHALL hold X[r][1]; each returned word SHALL be captured into a 2xMAX_ROWS local buffer.
REQ-020 Captured values SHALL be saturated from signed 32 bits to signed 16 bits: >32767 -> 0x7FFF; <-32768 -> 0x8000; otherwise the low 16 bits.
REQ-021 FETCH SHALL transition to STREAM on the cycle after the last word is captured; with start accepted at edge T, rd_en is high in cycles T+1..T+2N, and valid first rises in cycle T+2N+2.
REQ-022 STREAM SHALL last exactly N+1 cycles with valid=1 throughout; in stream cycle s (0..N): a_in1 = X[s][0] if s<N else 0, and a_in2 = X[s-1][1] if s>=1 else 0.
REQ-023 When valid=0, a_in1 and a_in2 SHALL be 0.
REQ-024 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-025 start SHALL be ignored in FETCH, STREAM and DONE; a start in IDLE on the cycle after DONE SHALL be accepted.
REQ-026 With N=0, no rd_en and no valid SHALL be produced; done SHALL pulse in cycle T+1.
REQ-027 rd_en SHALL be 0 outside FETCH, and rd_addr SHALL be 0 when rd_en=0.

Reset
REQ-028 With reset=1 at an edge, the block SHALL enter IDLE with rd_en, rd_addr, valid, a_in1, a_in2, busy and done all 0 after that edge.
REQ-029 Reset asserted mid-FETCH or mid-STREAM SHALL abort the transfer without emitting done; local buffer contents need not be cleared.
REQ-030 Reset SHALL take priority over a coincident start.

Verification
REQ-031 base=4, N=2, words 4..7 = 1,2,3,4, start at T -> rd_en in T+1..T+4 at addresses 4..7; valid in T+6..T+8; (a_in1,a_in2) = (1,0), (3,2), (0,4); done in T+9.
REQ-032 base=62, N=1, words 62,63 = 5,6 -> rd_addr sequence 62, 63; stream (5,0), (0,6); no access to address 0.
REQ-033 Words holding 0x00010000 and 0xFFFE0000 -> activations 0x7FFF and 0x8000; word 0xFFFFFFF6 -> 0xFFF6.
REQ-034 num_rows=0 -> no rd_en, no valid, done in T+1; num_rows=12 -> N clamped to 8, 16 reads, 9 valid cycles.
REQ-035 start pulsed during STREAM -> ignored, single done; reset in the 2nd STREAM cycle -> all outputs 0 the next cycle, no done, and a new start is accepted normally.
